// File: rtl/jtag_shift_master.sv
// Bit-serial JTAG initiator: turns packed TMS/TDI shift commands into
// TCK/TMS/TDI waveforms and returns the TDO bits captured on each TCK rise.
module jtag_shift_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_len_i,
  input  logic [31:0] cmd_tms_i,
  input  logic [31:0] cmd_tdi_i,
  input  logic        trst_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_tdo_o,
  output logic        busy_o,
  output logic        jtag_tck_o,
  output logic        jtag_tms_o,
  output logic        jtag_tdi_o,
  output logic        jtag_trst_no,
  input  logic        jtag_tdo_i
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_e;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  len_q, len_d;
  logic [31:0] tms_q, tms_d;
  logic [31:0] tdi_q, tdi_d;
  logic [31:0] cap_q, cap_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        tck_q, tck_d;
  logic        tms_out_q, tms_out_d;
  logic        tdi_out_q, tdi_out_d;
  logic        trst_n_q;

  logic        accept;
  logic        handshake;
  logic        last_phase;
  logic        last_bit;
  logic [5:0]  eff_len;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    len_d       = len_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cap_d       = cap_q;
    tms_out_d   = tms_out_q;
    tdi_out_d   = tdi_out_q;

    accept      = ready_q && cmd_valid_i;
    handshake   = rsp_valid_q && rsp_ready_i;
    last_phase  = (phase_q == PHASE_LAST);
    last_bit    = ({1'b0, idx_q} == (len_q - 6'd1));
    eff_len     = (cmd_len_i > 6'd32) ? 6'd32 : cmd_len_i;

    case (state_q)
      IDLE: begin
        if (accept) begin
          tms_d   = cmd_tms_i;
          tdi_d   = cmd_tdi_i;
          len_d   = eff_len;
          idx_d   = 5'd0;
          cap_d   = 32'd0;
          phase_d = 8'd0;
          state_d = (eff_len == 6'd0) ? RESP : LOW;
        end
      end
      LOW: begin
        if (last_phase) begin
          phase_d = 8'd0;
          state_d = HIGH;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      HIGH: begin
        // First HIGH cycle is the edge that raises TCK, so TDO is sampled here.
        if (phase_q == 8'd0) begin
          cap_d[idx_q] = jtag_tdo_i;
        end
        if (last_phase) begin
          phase_d = 8'd0;
          if (last_bit) begin
            state_d = RESP;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = LOW;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      RESP: begin
        if (handshake) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs follow the registered state by one cycle.
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_q == RESP) && !handshake;
    tck_d       = (state_q == HIGH);
    if (state_q == LOW) begin
      tms_out_d = tms_q[idx_q];
      tdi_out_d = tdi_q[idx_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      phase_q     <= 8'd0;
      idx_q       <= 5'd0;
      len_q       <= 6'd0;
      tms_q       <= 32'd0;
      tdi_q       <= 32'd0;
      cap_q       <= 32'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
      tms_out_q   <= 1'b1;
      tdi_out_q   <= 1'b0;
      trst_n_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cap_q       <= cap_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      tck_q       <= tck_d;
      tms_out_q   <= tms_out_d;
      tdi_out_q   <= tdi_out_d;
      trst_n_q    <= !trst_i;
    end
  end

  assign cmd_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_tdo_o    = cap_q;
  assign busy_o       = (state_q != IDLE);
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_out_q;
  assign jtag_tdi_o   = tdi_out_q;
  assign jtag_trst_no = trst_n_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Self-checking bench for jtag_shift_master: a negedge monitor checks TCK
// timing and the response scoreboard, scenario tasks check the rest.
module tb_jtag_shift_master;

  localparam int D = 2;
  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [5:0]  cmd_len_i = 6'd0;
  logic [31:0] cmd_tms_i = 32'd0;
  logic [31:0] cmd_tdi_i = 32'd0;
  logic        trst_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_tdo_o;
  logic        busy_o;
  logic        jtag_tck_o;
  logic        jtag_tms_o;
  logic        jtag_tdi_o;
  logic        jtag_trst_no;
  logic        jtag_tdo_i;

  logic        loopback = 1'b0;
  logic        tdo_level = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign jtag_tdo_i = loopback ? jtag_tdi_o : tdo_level;

  jtag_shift_master #(.CLK_DIV(D)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i), .cmd_tms_i(cmd_tms_i), .cmd_tdi_i(cmd_tdi_i),
    .trst_i(trst_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tdo_o(rsp_tdo_o),
    .busy_o(busy_o),
    .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
    .jtag_trst_no(jtag_trst_no), .jtag_tdo_i(jtag_tdo_i)
  );

  typedef struct {
    logic [31:0] tdo;
    int          acc_cyc;
    int          len;
    int          rises0;
  } exp_t;

  exp_t sb[$];

  int          cyc = 0;
  int          acc_count = 0, hs_count = 0, tck_rises = 0;
  int          acc_cyc = 0, hs_cyc = 0, rsp_rise_cyc = 0;
  int          last_rise_cyc = 0, last_fall_cyc = 0, bit_k = 0;
  int          cur_len = 0;
  logic [31:0] cur_tms = 32'd0, cur_tdi = 32'd0;
  bit          in_cmd = 1'b0;
  logic        prev_tck = 1'b0, prev_rsp = 1'b0;

  function automatic logic [31:0] len_mask(int n);
    logic [31:0] ones;
    ones = '1;
    if (n >= 32) return ones;
    return (32'd1 << n) - 32'd1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs only change on posedge, so each negedge sees one cycle.
  always @(negedge clk) begin
    exp_t e;
    int   eff;
    if (rst_i) begin
      sb.delete();
      in_cmd = 1'b0;
    end else begin
      if (jtag_tck_o === 1'b1 && prev_tck === 1'b0) begin
        n_cmp++;
        if (!in_cmd || bit_k >= cur_len) begin
          n_bad++;
          $display("[TB] FAIL extra_tck_pulse: pulse %0d seen, allowed %0d", bit_k, cur_len);
        end else begin
          n_cmp++;
          if (bit_k == 0 && cyc - acc_cyc != D + 1) begin
            n_bad++;
            $display("[TB] FAIL first_rise_latency: got %0d expected %0d", cyc - acc_cyc, D + 1);
          end else if (bit_k != 0 && cyc - last_fall_cyc != D) begin
            n_bad++;
            $display("[TB] FAIL tck_low_time: got %0d expected %0d", cyc - last_fall_cyc, D);
          end
          n_cmp++;
          if (jtag_tms_o !== cur_tms[bit_k] || jtag_tdi_o !== cur_tdi[bit_k]) begin
            n_bad++;
            $display("[TB] FAIL tms_tdi_bit%0d: got tms=%b tdi=%b expected tms=%b tdi=%b",
                     bit_k, jtag_tms_o, jtag_tdi_o, cur_tms[bit_k], cur_tdi[bit_k]);
          end
        end
        bit_k++;
        tck_rises++;
        last_rise_cyc = cyc;
      end
      if (jtag_tck_o === 1'b0 && prev_tck === 1'b1) begin
        n_cmp++;
        if (cyc - last_rise_cyc != D) begin
          n_bad++;
          $display("[TB] FAIL tck_high_time: got %0d expected %0d", cyc - last_rise_cyc, D);
        end
        last_fall_cyc = cyc;
      end
      if (rsp_valid_o === 1'b1 && prev_rsp !== 1'b1) rsp_rise_cyc = cyc;
      if (rsp_valid_o === 1'b1 && rsp_ready_i) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL unexpected_rsp: got tdo=%h expected no response", rsp_tdo_o);
        end else begin
          e = sb.pop_front();
          if (rsp_tdo_o !== e.tdo) begin
            n_bad++;
            $display("[TB] FAIL rsp_tdo: got %h expected %h", rsp_tdo_o, e.tdo);
          end
          n_cmp++;
          if (rsp_rise_cyc - e.acc_cyc != 2 * D * e.len + 1) begin
            n_bad++;
            $display("[TB] FAIL rsp_latency: got %0d expected %0d",
                     rsp_rise_cyc - e.acc_cyc, 2 * D * e.len + 1);
          end
          n_cmp++;
          if (tck_rises - e.rises0 != e.len) begin
            n_bad++;
            $display("[TB] FAIL tck_pulse_count: got %0d expected %0d", tck_rises - e.rises0, e.len);
          end
        end
        hs_cyc = cyc + 1;
        hs_count++;
        in_cmd = 1'b0;
      end
      if (cmd_valid_i && cmd_ready_o === 1'b1) begin
        eff = (cmd_len_i > 6'd32) ? 32 : int'(cmd_len_i);
        e.len     = eff;
        e.acc_cyc = cyc + 1;
        e.rises0  = tck_rises;
        e.tdo     = loopback ? (cmd_tdi_i & len_mask(eff)) : (tdo_level ? len_mask(eff) : 32'd0);
        sb.push_back(e);
        acc_cyc = cyc + 1;
        acc_count++;
        cur_len = eff;
        cur_tms = cmd_tms_i;
        cur_tdi = cmd_tdi_i;
        bit_k   = 0;
        in_cmd  = 1'b1;
      end
    end
    prev_tck = jtag_tck_o;
    prev_rsp = rsp_valid_o;
  end

  task automatic drive_cmd(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi);
    int a0;
    a0 = acc_count;
    cmd_valid_i = 1'b1;
    cmd_len_i   = len;
    cmd_tms_i   = tms;
    cmd_tdi_i   = tdi;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      if (acc_count != a0) break;
    end
    #1;
    cmd_valid_i = 1'b0;
    if (acc_count == a0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept within %0d cycles", BUDGET);
    end
  endtask

  task automatic wait_rsp();
    int h0;
    h0 = hs_count;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      if (hs_count != h0) break;
    end
    #1;
    if (hs_count == h0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL rsp_timeout: got no response expected one within %0d cycles", BUDGET);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, rsp_valid_o, cmd_ready_o, busy_o} !== 7'b0100000) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs: got %b expected 0100000",
                 {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, rsp_valid_o, cmd_ready_o, busy_o});
      end
    end
    n_cmp++;
    if (rsp_tdo_o !== 32'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_rsp_tdo: got %h expected 00000000", rsp_tdo_o);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || jtag_trst_no !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL release_ready: got ready=%b trst_n=%b expected 1 1", cmd_ready_o, jtag_trst_no);
    end
  endtask

  task automatic test_tms_pulses();
    int r0;
    loopback = 1'b0;
    tdo_level = 1'b0;
    r0 = tck_rises;
    drive_cmd(6'd5, 32'h1F, 32'h0);
    wait_rsp();
    n_cmp++;
    if (tck_rises - r0 != 5) begin
      n_bad++;
      $display("[TB] FAIL tms_pulse_count: got %0d expected 5", tck_rises - r0);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (jtag_tms_o !== 1'b1 || jtag_tck_o !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL tms_hold: got tms=%b tck=%b expected 1 0", jtag_tms_o, jtag_tck_o);
    end
  endtask

  task automatic test_loopback();
    loopback = 1'b1;
    drive_cmd(6'd8, 32'h0, 32'hA5);
    wait_rsp();
    drive_cmd(6'd32, 32'h0, 32'hDEADBEEF);
    wait_rsp();
    n_cmp++;
    if (jtag_tdi_o !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL tdi_hold: got %b expected 1", jtag_tdi_o);
    end
    loopback = 1'b0;
    tdo_level = 1'b1;
    drive_cmd(6'd7, 32'h55, 32'h0);
    wait_rsp();
    tdo_level = 1'b0;
  endtask

  task automatic test_len_edges();
    int r0;
    logic [31:0] rnd;
    loopback = 1'b1;
    r0 = tck_rises;
    drive_cmd(6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rsp();
    n_cmp++;
    if (tck_rises != r0) begin
      n_bad++;
      $display("[TB] FAIL len0_no_tck: got %0d pulses expected 0", tck_rises - r0);
    end
    rnd = $urandom;
    r0 = tck_rises;
    drive_cmd(6'd40, 32'h0, rnd);
    wait_rsp();
    n_cmp++;
    if (tck_rises - r0 != 32) begin
      n_bad++;
      $display("[TB] FAIL len40_saturate: got %0d pulses expected 32", tck_rises - r0);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    loopback = 1'b1;
    rsp_ready_i = 1'b0;
    drive_cmd(6'd4, 32'h0, 32'hFFFFFFF9);
    for (int i = 0; i < BUDGET && rsp_valid_o !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    cmd_valid_i = 1'b1;
    cmd_len_i   = 6'd3;
    cmd_tms_i   = 32'h0;
    cmd_tdi_i   = 32'h5;
    a0 = acc_count;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({rsp_valid_o, jtag_tck_o, cmd_ready_o} !== 3'b100 || rsp_tdo_o !== 32'h9) begin
        n_bad++;
        $display("[TB] FAIL backpressure_hold: got valid/tck/ready=%b tdo=%h expected 100 00000009",
                 {rsp_valid_o, jtag_tck_o, cmd_ready_o}, rsp_tdo_o);
      end
    end
    rsp_ready_i = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      if (acc_count != a0) break;
    end
    #1;
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (acc_count == a0 || acc_cyc != hs_cyc + 1) begin
      n_bad++;
      $display("[TB] FAIL pending_accept: got accept at %0d expected %0d", acc_cyc, hs_cyc + 1);
    end
    wait_rsp();
  endtask

  task automatic test_reset_mid();
    int  r0, h0;
    bit  saw;
    loopback = 1'b1;
    r0 = tck_rises;
    drive_cmd(6'd16, 32'h0, 32'hBEEF);
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk); #1;
      if (tck_rises - r0 >= 3) break;
    end
    h0 = hs_count;
    rst_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({jtag_tck_o, jtag_tms_o, jtag_tdi_o, busy_o, rsp_valid_o} !== 5'b01000) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_outputs: got %b expected 01000",
               {jtag_tck_o, jtag_tms_o, jtag_tdi_o, busy_o, rsp_valid_o});
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_o !== 1'b0) saw = 1'b1;
    end
    n_cmp++;
    if (saw || hs_count != h0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_no_rsp: got rsp_valid seen=%0d expected 0", saw);
    end
  endtask

  task automatic test_trst();
    loopback = 1'b1;
    drive_cmd(6'd8, 32'h0, 32'h3C);
    trst_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (jtag_trst_no !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL trst_assert: got trst_n=%b busy=%b expected 0 1", jtag_trst_no, busy_o);
    end
    wait_rsp();
    trst_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (jtag_trst_no !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL trst_release: got %b expected 1", jtag_trst_no);
    end
  endtask

  initial begin
    test_reset();
    test_tms_pulses();
    test_loopback();
    test_len_edges();
    test_backpressure();
    test_reset_mid();
    test_trst();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
